// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
// Holds FSM state enum, bus owner enum and the byte-enable width.
`ifndef XLEN
`define XLEN 32
`endif

package mem_port_arbiter_pkg;

   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between fetch (IF) and data (DM).
// Ports: i_clk/i_rst_n; IF req/addr/flush -> rvalid/rdata/stall;
// DM req/we/addr/wdata/be -> rvalid/rdata/stall; bus req/we/addr/
// wdata/be out, gnt/rvalid/rdata in. One outstanding transaction.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [`XLEN-1:0]  i_if_addr,
   input  logic              i_flush,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [`XLEN-1:0]  i_dm_addr,
   input  logic [`XLEN-1:0]  i_dm_wdata,
   input  logic [BE_W-1:0]   i_dm_be,
   output logic              o_if_rvalid,
   output logic [`XLEN-1:0]  o_if_rdata,
   output logic              o_dm_rvalid,
   output logic [`XLEN-1:0]  o_dm_rdata,
   output logic              o_if_stall,
   output logic              o_dm_stall,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [`XLEN-1:0]  o_bus_addr,
   output logic [`XLEN-1:0]  o_bus_wdata,
   output logic [BE_W-1:0]   o_bus_be,
   input  logic              i_bus_gnt,
   input  logic              i_bus_rvalid,
   input  logic [`XLEN-1:0]  i_bus_rdata
);

   state_e             r_state;
   state_e             w_state_nxt;
   owner_e             r_owner;
   owner_e             w_owner_nxt;
   logic               r_drop;
   logic               w_drop_nxt;
   logic               r_we;
   logic               w_we_nxt;
   logic [`XLEN-1:0]   r_addr;
   logic [`XLEN-1:0]   w_addr_nxt;
   logic [`XLEN-1:0]   r_wdata;
   logic [`XLEN-1:0]   w_wdata_nxt;
   logic [BE_W-1:0]    r_be;
   logic [BE_W-1:0]    w_be_nxt;
   logic               w_if_flush;
   logic               w_resp;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_IF;
         r_drop  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_drop  <= w_drop_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_be    <= w_be_nxt;
      end
   end

   // A flush only concerns a fetch; data accesses are never dropped.
   assign w_if_flush = i_flush & (r_owner == OWN_IF);

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_drop_nxt  = r_drop;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_be_nxt    = r_be;
      unique case (r_state)
         ST_IDLE: begin
            w_drop_nxt = 1'b0;
            if (i_dm_req) begin
               w_owner_nxt = OWN_DM;
               w_we_nxt    = i_dm_we;
               w_addr_nxt  = i_dm_addr;
               w_wdata_nxt = i_dm_wdata;
               w_be_nxt    = i_dm_be;
               w_state_nxt = ST_ADDR;
            end else if (i_if_req && !i_flush) begin
               w_owner_nxt = OWN_IF;
               w_we_nxt    = 1'b0;
               w_addr_nxt  = i_if_addr;
               w_wdata_nxt = '0;
               w_be_nxt    = {BE_W{1'b1}};
               w_state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (w_if_flush) w_drop_nxt = 1'b1;
            if (i_bus_gnt) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_if_flush) w_drop_nxt = 1'b1;
            if (i_bus_rvalid) begin
               w_state_nxt = ST_IDLE;
               w_drop_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_drop_nxt  = 1'b0;
         end
      endcase
   end

   assign o_bus_req   = (r_state == ST_ADDR);
   assign o_bus_we    = r_we;
   assign o_bus_addr  = r_addr;
   assign o_bus_wdata = r_wdata;
   assign o_bus_be    = r_be;

   assign w_resp = (r_state == ST_DATA) & i_bus_rvalid;

   // A flush landing in the same cycle as the response also kills it,
   // since the flag would only be visible a cycle too late.
   assign o_dm_rvalid = w_resp & (r_owner == OWN_DM);
   assign o_if_rvalid = w_resp & (r_owner == OWN_IF)
                      & ~r_drop & ~i_flush;
   assign o_if_rdata  = i_bus_rdata;
   assign o_dm_rdata  = i_bus_rdata;

   assign o_if_stall = i_if_req & ~o_if_rvalid;
   assign o_dm_stall = i_dm_req & ~o_dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model
// compared every cycle plus hand-computed literal checks.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_port_arbiter;

   logic              clk;
   logic              rst_n;
   logic              if_req;
   logic [`XLEN-1:0]  if_addr;
   logic              flush;
   logic              dm_req;
   logic              dm_we;
   logic [`XLEN-1:0]  dm_addr;
   logic [`XLEN-1:0]  dm_wdata;
   logic [3:0]        dm_be;
   logic              if_rvalid;
   logic [`XLEN-1:0]  if_rdata;
   logic              dm_rvalid;
   logic [`XLEN-1:0]  dm_rdata;
   logic              if_stall;
   logic              dm_stall;
   logic              bus_req;
   logic              bus_we;
   logic [`XLEN-1:0]  bus_addr;
   logic [`XLEN-1:0]  bus_wdata;
   logic [3:0]        bus_be;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [`XLEN-1:0]  bus_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_if_req     (if_req),
      .i_if_addr    (if_addr),
      .i_flush      (flush),
      .i_dm_req     (dm_req),
      .i_dm_we      (dm_we),
      .i_dm_addr    (dm_addr),
      .i_dm_wdata   (dm_wdata),
      .i_dm_be      (dm_be),
      .o_if_rvalid  (if_rvalid),
      .o_if_rdata   (if_rdata),
      .o_dm_rvalid  (dm_rvalid),
      .o_dm_rdata   (dm_rdata),
      .o_if_stall   (if_stall),
      .o_dm_stall   (dm_stall),
      .o_bus_req    (bus_req),
      .o_bus_we     (bus_we),
      .o_bus_addr   (bus_addr),
      .o_bus_wdata  (bus_wdata),
      .o_bus_be     (bus_be),
      .i_bus_gnt    (bus_gnt),
      .i_bus_rvalid (bus_rvalid),
      .i_bus_rdata  (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // Transaction-level model: at most one pending transaction record.
   logic              m_busy    = 1'b0;
   logic              m_granted = 1'b0;
   logic              m_stale   = 1'b0;
   logic              m_dm      = 1'b0;
   logic              m_we      = 1'b0;
   logic [`XLEN-1:0]  m_addr    = '0;
   logic [`XLEN-1:0]  m_wdata   = '0;
   logic [3:0]        m_be      = '0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy    = 1'b0;
            m_granted = 1'b0;
            m_stale   = 1'b0;
         end else if (!m_busy) begin
            if (dm_req) begin
               m_busy = 1'b1; m_granted = 1'b0; m_stale = 1'b0;
               m_dm = 1'b1; m_we = dm_we; m_addr = dm_addr;
               m_wdata = dm_wdata; m_be = dm_be;
            end else if (if_req && !flush) begin
               m_busy = 1'b1; m_granted = 1'b0; m_stale = 1'b0;
               m_dm = 1'b0; m_we = 1'b0; m_addr = if_addr;
               m_wdata = '0; m_be = 4'hF;
            end
         end else begin
            if (!m_dm && flush) m_stale = 1'b1;
            if (!m_granted) begin
               if (bus_gnt) m_granted = 1'b1;
            end else if (bus_rvalid) begin
               m_busy  = 1'b0;
               m_stale = 1'b0;
            end
         end
      end
   end

   logic e_req, e_resp, e_dm_rv, e_if_rv;
   assign e_req   = m_busy & ~m_granted;
   assign e_resp  = m_busy & m_granted & bus_rvalid;
   assign e_dm_rv = e_resp & m_dm;
   assign e_if_rv = e_resp & ~m_dm & ~m_stale & ~flush;

   initial begin
      forever begin
         @(negedge clk);
         chk("m_bus_req", {31'd0, bus_req}, {31'd0, e_req});
         chk("m_dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e_dm_rv});
         chk("m_if_rvalid", {31'd0, if_rvalid}, {31'd0, e_if_rv});
         chk("m_if_stall", {31'd0, if_stall},
             {31'd0, if_req & ~e_if_rv});
         chk("m_dm_stall", {31'd0, dm_stall},
             {31'd0, dm_req & ~e_dm_rv});
         if (e_req) begin
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_we", {31'd0, bus_we}, {31'd0, m_we});
            chk("m_bus_be", {28'd0, bus_be}, {28'd0, m_be});
            if (m_dm) chk("m_bus_wdata", bus_wdata, m_wdata);
         end
         if (e_if_rv) chk("m_if_rdata", if_rdata, bus_rdata);
         if (e_dm_rv) chk("m_dm_rdata", dm_rdata, bus_rdata);
      end
   end

   // Advance to just after the next rising edge, then drive inputs.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      dm_be = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

      // reset state
      at_neg();
      bus_rvalid = 1'b1;
      #1;
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      bus_rvalid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // IF-only read, immediate grant, response next cycle
      if_req = 1'b1; if_addr = 32'h40;
      at_neg();
      chk("if_n_req", {31'd0, bus_req}, 32'd0);
      chk("if_n_stall", {31'd0, if_stall}, 32'd1);
      tick();
      bus_gnt = 1'b1;
      at_neg();
      chk("if_n1_req", {31'd0, bus_req}, 32'd1);
      chk("if_n1_addr", bus_addr, 32'h40);
      chk("if_n1_be", {28'd0, bus_be}, 32'hF);
      tick();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      at_neg();
      chk("if_n2_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("if_n2_rdata", if_rdata, 32'hDEAD_BEEF);
      chk("if_n2_stall", {31'd0, if_stall}, 32'd0);
      chk("if_n2_req", {31'd0, bus_req}, 32'd0);
      tick();
      bus_rvalid = 1'b0; if_req = 1'b0;
      at_neg();
      chk("if_n3_rvalid", {31'd0, if_rvalid}, 32'd0);
      tick();

      // stray rvalid in IDLE is ignored
      bus_rvalid = 1'b1; bus_rdata = 32'h5555_0000;
      at_neg();
      chk("idle_rv_dm", {31'd0, dm_rvalid}, 32'd0);
      tick();
      bus_rvalid = 1'b0;

      // simultaneous IF + DM store: DM first
      if_req = 1'b1; if_addr = 32'h80;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100;
      dm_wdata = 32'h1234_5678; dm_be = 4'b0011;
      tick();
      at_neg();
      chk("pri_req", {31'd0, bus_req}, 32'd1);
      chk("pri_we", {31'd0, bus_we}, 32'd1);
      chk("pri_addr", bus_addr, 32'h100);
      chk("pri_be", {28'd0, bus_be}, 32'h3);
      chk("pri_wdata", bus_wdata, 32'h1234_5678);
      bus_rvalid = 1'b1;
      #1;
      chk("addr_rv_ign", {31'd0, dm_rvalid}, 32'd0);
      bus_rvalid = 1'b0;
      tick();
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0;
      at_neg();
      chk("pri_dm_rv", {31'd0, dm_rvalid}, 32'd1);
      chk("pri_if_rv", {31'd0, if_rvalid}, 32'd0);
      chk("pri_if_stall", {31'd0, if_stall}, 32'd1);
      tick();
      bus_rvalid = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      at_neg();
      chk("pri_gap_req", {31'd0, bus_req}, 32'd0);
      tick();
      at_neg();
      chk("pri_if_req", {31'd0, bus_req}, 32'd1);
      chk("pri_if_addr", bus_addr, 32'h80);
      chk("pri_if_we", {31'd0, bus_we}, 32'd0);
      chk("pri_if_be", {28'd0, bus_be}, 32'hF);
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
      at_neg();
      chk("pri_if_rv", {31'd0, if_rvalid}, 32'd1);
      tick();
      bus_rvalid = 1'b0; if_req = 1'b0;
      tick();

      // delayed grant: request and fields stable for 4 cycles
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      dm_wdata = 32'hAAAA_AAAA; dm_be = 4'hF;
      tick();
      dm_addr = 32'h999; dm_be = 4'h1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus_gnt = 1'b1;
         at_neg();
         chk("dly_req", {31'd0, bus_req}, 32'd1);
         chk("dly_addr", bus_addr, 32'h200);
         chk("dly_be", {28'd0, bus_be}, 32'hF);
         chk("dly_stall", {31'd0, dm_stall}, 32'd1);
         tick();
      end
      bus_gnt = 1'b0;
      at_neg();
      chk("dly_data_stall", {31'd0, dm_stall}, 32'd1);
      tick();
      bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0001;
      flush = 1'b1;
      at_neg();
      chk("dly_rv", {31'd0, dm_rvalid}, 32'd1);
      chk("dly_rdata", dm_rdata, 32'hCAFE_0001);
      chk("dly_stall_lo", {31'd0, dm_stall}, 32'd0);
      tick();
      bus_rvalid = 1'b0; dm_req = 1'b0; flush = 1'b0;
      tick();

      // flush blocks a fetch in IDLE
      if_req = 1'b1; if_addr = 32'h44; flush = 1'b1;
      tick();
      flush = 1'b0;
      at_neg();
      chk("fl_idle_req", {31'd0, bus_req}, 32'd0);
      tick();
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; if_addr = 32'h88;
      bus_rvalid = 1'b1; bus_rdata = 32'h0000_0111;
      at_neg();
      chk("fl_rv", {31'd0, if_rvalid}, 32'd0);
      chk("fl_stall", {31'd0, if_stall}, 32'd1);
      tick();
      bus_rvalid = 1'b0;
      at_neg();
      chk("fl_idle", {31'd0, bus_req}, 32'd0);
      tick();
      at_neg();
      chk("fl_next_addr", bus_addr, 32'h88);
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0222;
      at_neg();
      chk("fl_next_rv", {31'd0, if_rvalid}, 32'd1);
      chk("fl_next_rdata", if_rdata, 32'h0000_0222);
      tick();
      bus_rvalid = 1'b0;

      // reset in DATA abandons the fetch
      tick();
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_data_req", {31'd0, bus_req}, 32'd0);
      if_req = 1'b0;
      bus_rvalid = 1'b1;
      #1;
      chk("rst_data_rv", {31'd0, if_rvalid}, 32'd0);
      tick();
      rst_n = 1'b1;
      at_neg();
      chk("post_rst_rv", {31'd0, if_rvalid}, 32'd0);
      tick();
      bus_rvalid = 1'b0;

      // reset in ADDR drops the request without a clock
      dm_req = 1'b1; dm_addr = 32'h300;
      tick();
      #1;
      chk("pre_rst_addr_req", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_addr_req", {31'd0, bus_req}, 32'd0);
      chk("rst_addr_stall", {31'd0, dm_stall}, 32'd1);
      dm_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have i_rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have i_if_req  in  1  fetch read request, held until o_if_rvalid.
REQ-004 SHALL have i_if_addr  in  `XLEN  fetch address.
REQ-005 SHALL have i_flush  in  1  branch/jump flush; fetch in flight becomes stale.
REQ-006 SHALL have i_dm_req, i_dm_we  in  1 each  data-side request and write-enable, held until o_dm_rvalid.
REQ-007 SHALL have i_dm_addr, i_dm_wdata  in  `XLEN each; i_dm_be  in  4  byte enables.
REQ-008 SHALL have o_if_rvalid, o_dm_rvalid  out  1 each; o_if_rdata, o_dm_rdata  out  `XLEN each.
REQ-009 SHALL have o_if_stall, o_dm_stall  out  1 each  to stall_controller/pipeline.
REQ-010 SHALL have o_bus_req, o_bus_we  out  1 each; o_bus_addr, o_bus_wdata  out  `XLEN; o_bus_be  out  4.
REQ-011 SHALL have i_bus_gnt, i_bus_rvalid  in  1 each; i_bus_rdata  in  `XLEN; one outstanding transaction maximum; writes also return i_bus_rvalid.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-013 IDLE: if i_dm_req, SHALL capture DM fields into registers, owner=DM, go ADDR; else if i_if_req and not i_flush, capture i_if_addr with we=0 and be=4'hF, owner=IF, go ADDR; else stay.
REQ-014 DM SHALL have strict priority over IF (older instruction).
REQ-015 ADDR: o_bus_req=1 with captured fields held stable; on i_bus_gnt go DATA; otherwise stay.
REQ-016 DATA: o_bus_req=0; on i_bus_rvalid return to IDLE.
REQ-017 Response SHALL be combinational in DATA: o_dm_rvalid = i_bus_rvalid when owner=DM; o_if_rvalid = i_bus_rvalid when owner=IF and drop flag clear; o_*_rdata = i_bus_rdata.
REQ-018 Minimum latency SHALL be: request cycle N, o_bus_req cycle N+1, rvalid/response no earlier than cycle N+2.
REQ-019 o_if_stall SHALL be i_if_req & ~o_if_rvalid; o_dm_stall SHALL be i_dm_req & ~o_dm_rvalid.
REQ-020 i_flush while owner=IF in ADDR or DATA SHALL set a drop flag; the transaction SHALL complete on the bus (no request withdrawal) and the response SHALL be suppressed; flag clears on return to IDLE.
REQ-021 i_flush with owner=DM SHALL have no effect.
REQ-022 i_bus_rvalid outside DATA SHALL be ignored; i_bus_gnt outside ADDR SHALL be ignored.
REQ-023 Back-to-back: from DATA with rvalid, the next arbitration SHALL occur in the following IDLE cycle (one idle bus cycle between transactions).

Reset
REQ-024 Reset SHALL force state=IDLE, drop flag=0, owner=IF, captured registers=0, o_bus_req=0, both rvalid=0.
REQ-025 Reset asserted mid-transaction SHALL abandon it immediately; the bus slave SHALL share i_rst_n.

Structure
REQ-026 The state enum, owner enum and bus byte-enable width SHALL live in the shared core package; `XLEN comes from the existing defines.
REQ-027 The block SHALL be a single module with no sub-modules.

Verification
REQ-028 IF-only read, gnt same cycle, rvalid one cycle later, rdata 32'hDEAD_BEEF -> o_bus_req one cycle, o_if_rvalid one cycle with 32'hDEAD_BEEF, o_if_stall low that cycle.
REQ-029 i_if_req and i_dm_req (store, addr 32'h100, be 4'b0011) in the same cycle -> DM issued first with o_bus_we=1, be 4'b0011; IF issued in the IDLE cycle after DM rvalid.
REQ-030 i_bus_gnt delayed 3 cycles -> o_bus_req and all bus fields stable for 4 cycles; o_dm_stall high throughout.
REQ-031 i_flush during IF DATA state -> o_if_rvalid stays 0 when i_bus_rvalid arrives; FSM returns to IDLE; next fetch proceeds normally.
REQ-032 i_rst_n low while in DATA -> o_bus_req=0 and state IDLE asynchronously; a subsequent rvalid pulse produces no response.
